// File: rtl/score_display.sv
// Multi-digit score display: a sequential double-dabble binary-to-BCD engine driving N_DIG active-low 7-segment digits.
// Optional macro SCORE_BLINK_EN makes the win/lose glyphs blink with a BLINK_DIV-clock half-period.
module score_display #(
    parameter int VAL_W     = 10,
    parameter int N_DIG     = 4,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [VAL_W-1:0]     value,
    input  logic [1:0]           mode,
    input  logic                 load,
    output logic                 busy,
    output logic                 done,
    output logic [7*N_DIG-1:0]   seg
);

    localparam int BCD_W = 4 * N_DIG;
    localparam int CNT_W = $clog2(VAL_W + 1);

    localparam logic [6:0] G_DASH  = 7'b0111111;
    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_WIN   = 7'b0001100;
    localparam logic [6:0] G_LOSE  = 7'b1000010;

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t             state_q, state_d;
    logic [VAL_W-1:0]   val_q, val_d;
    logic [1:0]         mode_q, mode_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7*N_DIG-1:0] seg_q, seg_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic [7*N_DIG-1:0] seg_new;
    logic               lead;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    digit_glyph = 7'b1000000;
            4'd1:    digit_glyph = 7'b1111001;
            4'd2:    digit_glyph = 7'b0100100;
            4'd3:    digit_glyph = 7'b0110000;
            4'd4:    digit_glyph = 7'b0011001;
            4'd5:    digit_glyph = 7'b0010010;
            4'd6:    digit_glyph = 7'b0000010;
            4'd7:    digit_glyph = 7'b1111000;
            4'd8:    digit_glyph = 7'b0000000;
            4'd9:    digit_glyph = 7'b0010000;
            default: digit_glyph = G_DASH;
        endcase
    endfunction

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < N_DIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Display image built from the finished BCD word; digits above the leading non-zero one stay blank.
    always_comb begin
        seg_new = '1;
        lead    = 1'b1;
        case (mode_q)
            2'd0: begin
                if (ovf_q) begin
                    for (int k = 0; k < N_DIG; k++) seg_new[7*k +: 7] = G_DASH;
                end else begin
                    for (int k = N_DIG - 1; k >= 0; k--) begin
                        if (!(lead && (bcd_q[4*k +: 4] == 4'd0) && (k != 0))) begin
                            seg_new[7*k +: 7] = digit_glyph(bcd_q[4*k +: 4]);
                            lead = 1'b0;
                        end
                    end
                end
            end
            2'd1:    seg_new[7*(N_DIG-1) +: 7] = G_WIN;
            2'd2:    seg_new[7*(N_DIG-1) +: 7] = G_LOSE;
            default: seg_new[7*(N_DIG-1) +: 7] = G_BLANK;
        endcase
    end

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        mode_d  = mode_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    val_d   = value;
                    mode_d  = mode;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_W'(VAL_W);
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d = {bcd_adj[BCD_W-2:0], val_q[VAL_W-1]};
                ovf_d = ovf_q | bcd_adj[BCD_W-1];
                val_d = val_q << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = UPDATE;
            end
            UPDATE: begin
                seg_d   = seg_new;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            val_q   <= '0;
            mode_q  <= 2'd0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            seg_q   <= '1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            mode_q  <= mode_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

`ifdef SCORE_BLINK_EN
    localparam int BL_W = $clog2(BLINK_DIV + 1);

    logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            phase_q, phase_d;
    logic [1:0]      disp_mode_q, disp_mode_d;

    // Restarting on each update keeps a fresh glyph visible for a full half-period.
    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        disp_mode_d = disp_mode_q;
        if (blink_cnt_q == BL_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
        if (done_d) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
            disp_mode_d = mode_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            disp_mode_q <= 2'd3;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            disp_mode_q <= disp_mode_d;
        end
    end

    assign seg = (phase_q && (disp_mode_q == 2'd1 || disp_mode_q == 2'd2)) ? '1 : seg_q;
`else
    assign seg = seg_q;
`endif

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: a 4-digit and a 3-digit instance share stimulus and are
// compared against an arithmetic model of the display rules.
module tb_score_display;

    localparam int VAL_W = 10;
    localparam int LAT   = VAL_W + 1;
    localparam int BLINK = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [VAL_W-1:0] value = '0;
    logic [1:0]       mode = 2'd0;
    logic             load = 1'b0;
    logic             busy4, done4, busy3, done3;
    logic [27:0]      seg4;
    logic [20:0]      seg3;

    int checks = 0;
    int errors = 0;
    logic [27:0] exp_q[$];
    logic [20:0] exp3_q[$];

    always #5 clk = ~clk;

    score_display #(.VAL_W(VAL_W), .N_DIG(4), .BLINK_DIV(BLINK)) dut4 (
        .clk(clk), .rst_n(rst_n), .value(value), .mode(mode), .load(load),
        .busy(busy4), .done(done4), .seg(seg4)
    );

    score_display #(.VAL_W(VAL_W), .N_DIG(3), .BLINK_DIV(BLINK)) dut3 (
        .clk(clk), .rst_n(rst_n), .value(value), .mode(mode), .load(load),
        .busy(busy3), .done(done3), .seg(seg3)
    );

    function automatic logic [6:0] glyph(input int d);
        logic [6:0] tab [0:9];
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return tab[d];
    endfunction

    // Decimal rendering straight from the display rules: divide out digits, blank leading zeros.
    function automatic logic [27:0] model_seg(input int unsigned v, input int md, input int nd);
        logic [27:0] r;
        int unsigned p;
        r = '1;
        p = 1;
        for (int i = 0; i < nd; i++) p = p * 10;
        if (md == 1) r[7*(nd-1) +: 7] = 7'b0001100;
        else if (md == 2) r[7*(nd-1) +: 7] = 7'b1000010;
        else if (md == 0) begin
            if (v >= p) begin
                for (int k = 0; k < nd; k++) r[7*k +: 7] = 7'b0111111;
            end else begin
                p = 1;
                for (int k = 0; k < nd; k++) begin
                    if (k == 0 || v >= p) r[7*k +: 7] = glyph(int'((v / p) % 10));
                    p = p * 10;
                end
            end
        end
        return r;
    endfunction

    // Presents a load for exactly one sampling edge; returns just after that edge.
    task automatic drive_load(input int unsigned v, input int md);
        @(negedge clk);
        value = VAL_W'(v);
        mode  = 2'(md);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Cycles until done is seen, or -1 when the bound runs out.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done4 === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (seg4 !== '1) begin errors++; $display("FAIL reset_seg4: got %h expected %h", seg4, 28'hfffffff); end
        checks++; if (seg3 !== '1) begin errors++; $display("FAIL reset_seg3: got %h expected %h", seg3, 21'h1fffff); end
        checks++; if ({busy4, done4, busy3, done3} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {busy4, done4, busy3, done3}); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (seg4 !== '1 || busy4 !== 1'b0) begin errors++; $display("FAIL after_release: seg %h busy %b expected all ones / 0", seg4, busy4); end
    endtask

    task automatic test_zero;
        int lat;
        drive_load(0, 0);
        wait_done(lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL zero_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (seg4 !== model_seg(0, 0, 4)) begin errors++; $display("FAIL zero_seg4: got %h expected %h", seg4, model_seg(0, 0, 4)); end
        checks++; if (seg4 !== {7'h7f, 7'h7f, 7'h7f, 7'b1000000}) begin errors++; $display("FAIL zero_literal: got %h expected blank blank blank 0", seg4); end
        @(negedge clk);
        checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", done4); end
    endtask

    task automatic test_max_busy;
        int lat;
        int bad;
        bad = 0;
        lat = -1;
        drive_load(1023, 0);
        for (int i = 1; i <= LAT; i++) begin
            if (busy4 !== 1'b1 || done4 !== 1'b0) bad++;
            @(negedge clk);
            if (done4 === 1'b1) lat = i;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL busy_window: got %0d bad cycles expected 0", bad); end
        checks++; if (lat !== LAT) begin errors++; $display("FAIL max_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %b expected 0", busy4); end
        checks++; if (seg4 !== {7'b1111001, 7'b1000000, 7'b0100100, 7'b0110000}) begin errors++; $display("FAIL seg_1023: got %h expected 1023 glyphs", seg4); end
        checks++; if (seg3 !== {3{7'b0111111}}) begin errors++; $display("FAIL ovf3_1023: got %h expected dashes", seg3); end
    endtask

    task automatic test_overflow;
        int lat;
        drive_load(1000, 0);
        wait_done(lat);
        checks++; if (seg3 !== {3{7'b0111111}}) begin errors++; $display("FAIL ovf3_1000: got %h expected dashes", seg3); end
        checks++; if (seg4 !== model_seg(1000, 0, 4)) begin errors++; $display("FAIL seg4_1000: got %h expected %h", seg4, model_seg(1000, 0, 4)); end
        drive_load(999, 0);
        wait_done(lat);
        checks++; if (seg3 !== {3{7'b0010000}}) begin errors++; $display("FAIL seg3_999: got %h expected 999", seg3); end
        checks++; if (done3 !== 1'b1) begin errors++; $display("FAIL done3_sync: got %b expected 1", done3); end
    endtask

    task automatic test_glyphs;
        int lat;
        drive_load(42, 1);
        wait_done(lat);
        checks++; if (seg4 !== {7'b0001100, 7'h7f, 7'h7f, 7'h7f}) begin errors++; $display("FAIL win4: got %h expected P blank blank blank", seg4); end
        checks++; if (seg3 !== {7'b0001100, 7'h7f, 7'h7f}) begin errors++; $display("FAIL win3: got %h expected P blank blank", seg3); end
        drive_load(42, 2);
        wait_done(lat);
        checks++; if (seg4 !== {7'b1000010, 7'h7f, 7'h7f, 7'h7f}) begin errors++; $display("FAIL lose4: got %h expected G blank blank blank", seg4); end
        drive_load(42, 3);
        wait_done(lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL blank_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (seg4 !== '1) begin errors++; $display("FAIL blank4: got %h expected all ones", seg4); end
    endtask

    task automatic test_ignored_load;
        int lat;
        drive_load(100, 0);
        repeat (4) @(negedge clk);
        value = 10'd7;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        wait_done(lat);
        checks++; if (lat !== LAT - 5) begin errors++; $display("FAIL ignored_latency: got %0d expected %0d", lat, LAT - 5); end
        checks++; if (seg4 !== model_seg(100, 0, 4)) begin errors++; $display("FAIL ignored_seg: got %h expected %h", seg4, model_seg(100, 0, 4)); end
        drive_load(7, 0);
        wait_done(lat);
        checks++; if (seg4 !== model_seg(7, 0, 4)) begin errors++; $display("FAIL reload_seg: got %h expected %h", seg4, model_seg(7, 0, 4)); end
    endtask

    task automatic test_hold;
        int lat;
        drive_load(305, 0);
        wait_done(lat);
        value = 10'd888;
        mode  = 2'd1;
        repeat (6) @(negedge clk);
        checks++; if (seg4 !== model_seg(305, 0, 4)) begin errors++; $display("FAIL hold_seg: got %h expected %h", seg4, model_seg(305, 0, 4)); end
    endtask

    task automatic test_async_reset;
        int lat;
        int seen;
        drive_load(55, 0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (seg4 !== '1 || busy4 !== 1'b0) begin errors++; $display("FAIL async_reset: seg %h busy %b expected all ones / 0", seg4, busy4); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done4 === 1'b1 || busy4 === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL no_done_after_reset: got %0d active cycles expected 0", seen); end
        drive_load(55, 0);
        wait_done(lat);
        checks++; if (seg4 !== model_seg(55, 0, 4)) begin errors++; $display("FAIL post_reset_seg: got %h expected %h", seg4, model_seg(55, 0, 4)); end
    endtask

    task automatic test_back_to_back;
        int first;
        int second;
        first = -1;
        second = -1;
        @(negedge clk);
        value = 10'd321;
        mode  = 2'd0;
        load  = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done4 === 1'b1) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        load = 1'b0;
        checks++; if (second - first !== LAT + 1) begin errors++; $display("FAIL level_load_spacing: got %0d expected %0d", second - first, LAT + 1); end
        wait_done(first);
        checks++; if (seg4 !== model_seg(321, 0, 4)) begin errors++; $display("FAIL level_load_seg: got %h expected %h", seg4, model_seg(321, 0, 4)); end
    endtask

    task automatic test_random;
        int lat;
        int unsigned v;
        int md;
        logic [27:0] e4;
        logic [20:0] e3;
        for (int n = 0; n < 40; n++) begin
            v  = $urandom_range(0, 1023);
            if (n % 4 == 0) v = $urandom_range(0, 12);
            md = (n % 3 == 0) ? int'($urandom_range(0, 3)) : 0;
            exp_q.push_back(model_seg(v, md, 4));
            exp3_q.push_back(21'(model_seg(v, md, 3)));
            drive_load(v, md);
            wait_done(lat);
            e4 = exp_q.pop_front();
            e3 = exp3_q.pop_front();
            checks++; if (lat !== LAT || seg4 !== e4) begin errors++; $display("FAIL rand4 v=%0d m=%0d: got %h lat %0d expected %h lat %0d", v, md, seg4, lat, e4, LAT); end
            checks++; if (seg3 !== e3) begin errors++; $display("FAIL rand3 v=%0d m=%0d: got %h expected %h", v, md, seg3, e3); end
        end
    endtask

`ifdef SCORE_BLINK_EN
    task automatic test_blink;
        int lat;
        int bad;
        logic [27:0] e;
        bad = 0;
        drive_load(9, 1);
        wait_done(lat);
        for (int j = 0; j < 16; j++) begin
            e = ((j / BLINK) % 2 == 1) ? '1 : model_seg(9, 1, 4);
            if (seg4 !== e) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL blink_pattern: got %0d bad cycles expected 0", bad); end
    endtask
`endif

    initial begin
        test_reset();
        test_zero();
        test_max_busy();
        test_overflow();
        test_glyphs();
        test_ignored_load();
        test_hold();
        test_async_reset();
        test_back_to_back();
        test_random();
`ifdef SCORE_BLINK_EN
        test_blink();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
